// File: rtl/issue_scheduler.sv
// issue_scheduler: picks the oldest ready issue-queue slot each cycle, masks
// slots whose HI/LO or memory resource is busy, and reports the lowest free
// slot for rename enqueue together with the queue-full halt.
module issue_scheduler #(
   parameter int unsigned MULT_LAT = 4
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         STALL,
   input  logic         FLUSH,
   input  logic [15:0]  entry_valid,
   input  logic [15:0]  entry_ready,
   input  logic [15:0]  entry_hilo,
   input  logic [15:0]  entry_mem,
   input  logic [511:0] entry_num,
   input  logic         mem_done,
   output logic         grant_valid,
   output logic [3:0]   grant_index,
   output logic [15:0]  grant_onehot,
   output logic         mult_busy,
   output logic         mem_busy,
   output logic [4:0]   alloc_index,
   output logic         halt_rename
);

   localparam logic [3:0] MULT_LAT_C = 4'(MULT_LAT);

   logic        grant_valid_q, grant_valid_d;
   logic [3:0]  grant_index_q, grant_index_d;
   logic [15:0] grant_onehot_q, grant_onehot_d;
   logic [3:0]  mult_cnt_q, mult_cnt_d;
   logic        mem_inflight_q, mem_inflight_d;

   logic [15:0] elig;
   logic        mult_idle;
   logic        mem_free;
   logic        sel_vld;
   logic [3:0]  sel_idx;
   logic [31:0] sel_num;
   logic        sel_hilo;
   logic        sel_mem;
   logic [4:0]  alloc_idx;

   // A memory slot may go when nothing is in flight or the access completes this cycle.
   assign mult_idle = (mult_cnt_q == 4'd0);
   assign mem_free  = !mem_inflight_q || mem_done;

   // Eligibility: occupied, ready, not just issued, and its resources free.
   always_comb begin
      elig = entry_valid & entry_ready & ~grant_onehot_q;
      if (!mult_idle) begin
         elig = elig & ~entry_hilo;
      end
      if (!mem_free) begin
         elig = elig & ~entry_mem;
      end
   end

   // Oldest-first select; strict less-than keeps the lower index on equal numbers.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = 4'd0;
      sel_num = 32'd0;
      for (int i = 0; i < 16; i++) begin
         if (elig[i] && (!sel_vld || (entry_num[32*i +: 32] < sel_num))) begin
            sel_vld = 1'b1;
            sel_idx = 4'(i);
            sel_num = entry_num[32*i +: 32];
         end
      end
   end

   assign sel_hilo = sel_vld && entry_hilo[sel_idx];
   assign sel_mem  = sel_vld && entry_mem[sel_idx];

   // Next state: flush clears, stall holds (mem_done ignored), else advance.
   always_comb begin
      grant_valid_d  = grant_valid_q;
      grant_index_d  = grant_index_q;
      grant_onehot_d = grant_onehot_q;
      mult_cnt_d     = mult_cnt_q;
      mem_inflight_d = mem_inflight_q;
      if (FLUSH) begin
         grant_valid_d  = 1'b0;
         grant_index_d  = 4'd0;
         grant_onehot_d = 16'd0;
         mult_cnt_d     = 4'd0;
         mem_inflight_d = 1'b0;
      end else if (!STALL) begin
         grant_valid_d  = sel_vld;
         grant_index_d  = sel_idx;
         grant_onehot_d = sel_vld ? (16'd1 << sel_idx) : 16'd0;
         if (sel_hilo) begin
            mult_cnt_d = MULT_LAT_C;
         end else if (!mult_idle) begin
            mult_cnt_d = mult_cnt_q - 4'd1;
         end
         if (sel_mem) begin
            mem_inflight_d = 1'b1;
         end else if (mem_done) begin
            mem_inflight_d = 1'b0;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         grant_valid_q  <= 1'b0;
         grant_index_q  <= 4'd0;
         grant_onehot_q <= 16'd0;
         mult_cnt_q     <= 4'd0;
         mem_inflight_q <= 1'b0;
      end else begin
         grant_valid_q  <= grant_valid_d;
         grant_index_q  <= grant_index_d;
         grant_onehot_q <= grant_onehot_d;
         mult_cnt_q     <= mult_cnt_d;
         mem_inflight_q <= mem_inflight_d;
      end
   end

   // Lowest free slot for rename; 16 means the queue is full.
   always_comb begin
      alloc_idx = 5'd16;
      for (int i = 15; i >= 0; i--) begin
         if (!entry_valid[i]) begin
            alloc_idx = 5'(i);
         end
      end
   end

   assign grant_valid  = grant_valid_q;
   assign grant_index  = grant_index_q;
   assign grant_onehot = grant_onehot_q;
   assign mult_busy    = !mult_idle;
   assign mem_busy     = mem_inflight_q;
   assign alloc_index  = alloc_idx;
   assign halt_rename  = (alloc_idx == 5'd16);

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Select and sequencing controller for the 16-entry issue queue of the out-of-order core. Each cycle it picks the oldest ready entry, by ROB instruction number, that may leave for execution. It tracks occupancy of the non-pipelined HI/LO multiply/divide unit and the single memory port, and masks entries whose resource is busy. It also reports the lowest free slot for rename enqueue and produces the queue-full halt.

## Interface
Parameters:
- MULT_LAT, 4, cycles the HI/LO unit stays occupied after a hilo grant (legal range 1-15)

Ports:
- CLK  in  1  clock; all state on posedge
- RESET  in  1  asynchronous, active-low reset
- STALL  in  1  freezes all state and outputs
- FLUSH  in  1  synchronous clear of all state (mispredict)
- entry_valid  in  16  slot occupied
- entry_ready  in  16  all operands of slot available
- entry_hilo  in  16  slot needs the HI/LO unit
- entry_mem  in  16  slot is a load/store
- entry_num  in  512  ROB instruction number per slot, slot i at [32i+31:32i], unsigned
- mem_done  in  1  memory port finished its current access (1-cycle pulse)
- grant_valid  out  1  registered, an entry is issued this cycle
- grant_index  out  4  registered, issued slot
- grant_onehot  out  16  registered, one-hot of grant_index, all-zero when !grant_valid
- mult_busy  out  1  HI/LO unit occupied
- mem_busy  out  1  memory access in flight
- alloc_index  out  5  combinational, lowest-index slot with entry_valid=0, 16 if none
- halt_rename  out  1  combinational, alloc_index==16

## Operation
- Eligibility of slot i: entry_valid[i] & entry_ready[i] & !last_grant[i] & (!entry_hilo[i] | mult_cnt==0) & (!entry_mem[i] | !mem_inflight | mem_done).
- last_grant = grant_onehot register. The slot issued in the previous cycle is masked, because the queue clears it on the same edge the grant becomes visible.
- Selection: the eligible slot with the smallest entry_num. On equal numbers the lower index wins. No wrap-around handling; numbers are monotonic.
- No eligible slot: grant_valid=0, grant_index=0, grant_onehot=0 at next edge.
- HI/LO counter mult_cnt (4 bit):
  - A hilo grant loads MULT_LAT.
  - Otherwise it decrements while nonzero.
  - mult_busy = (mult_cnt!=0).
  - A grant can never occur while mult_cnt!=0, so a load always follows idle.
- Memory flag mem_inflight:
  - Set on a mem grant.
  - Else cleared on mem_done.
  - If mem_done arrives in the same cycle as a new mem grant, the flag stays 1.
  - mem_busy = mem_inflight.
  - A mem_done while idle is ignored.
- An entry with both hilo and mem set obeys both masks and updates both resources.

## Timing
- Reset (async, RESET low): grant_valid=0, grant_index=0, grant_onehot=0, mult_cnt=0, mem_inflight=0. Hence mult_busy=0 and mem_busy=0.
- Reset asserted mid-operation aborts any HI/LO count and in-flight memory tracking immediately.
- Select latency is 1 cycle: inputs sampled at edge t produce the grant in cycle t+1.
- Max one grant per cycle. Back-to-back grants to different slots are allowed every cycle.
- The same slot can be re-granted no earlier than 2 cycles after its previous grant, and only if still valid and ready.
- FLUSH (synchronous, RESET high) forces all registers to their reset values at the next edge and takes priority over STALL.
- STALL=1, FLUSH=0: every register holds, including mult_cnt, mem_inflight and grant outputs, and mem_done is ignored. The producer holds mem_done until STALL falls.
- alloc_index and halt_rename are purely combinational from entry_valid and unaffected by STALL.
- HI/LO: after a hilo grant at edge t, the next hilo grant occurs no earlier than edge t+MULT_LAT+1.

## Test plan
- Reset, then slots 3 (num 20) and 9 (num 12) valid and ready → next cycle grant_index=9, grant_onehot=0x0200; the following cycle slot 9 is masked and grant_index=3.
- MULT_LAT=4: hilo slot 0 (num 5) granted at edge t; hilo slot 1 (num 6) ready → mult_busy high t..t+3, slot 1 granted at edge t+5; a non-hilo slot 2 (num 7) is granted at t+1.
- Load slot 4 granted; store slot 6 ready; mem_done pulsed 3 cycles later → slot 6 granted on the edge sampling mem_done; mem_busy stays 1 throughout.
- Simultaneous: mem_done and a new mem grant in the same cycle → mem_busy stays 1; an extra mem_done while idle → mem_busy stays 0.
- STALL held 3 cycles during mult_cnt=2 → count and grant outputs frozen; FLUSH during a busy HI/LO unit → mult_busy=0 and grant_valid=0 next edge; RESET low mid-count → outputs zero immediately.
- entry_valid=0xFFFF → halt_rename=1, alloc_index=16; clear bit 7 → alloc_index=7 in the same cycle.
